// File: rtl/wormhole_arbiter.sv
// Per-output-port wormhole arbiter: round-robin grant on head flits, lock held until tail.
// Latency: grant registered one cycle after an eligible head is seen; one idle bubble after each tail.
// Backpressure: ready_i is fanned out to the owner only; non-owners and the owner while stalled see no pop.
//
// Ports:
//   clk, arst         router clock, asynchronous active-low reset
//   req_i/head_i/tail_i  per-requester flit valid and flit type
//   ready_i           output module accepts a flit this cycle
//   grant_o           one-hot owner (zero when idle), registered
//   valid_o/ready_o   owner flit valid / per-requester pop (combinational from grant_o)
//   busy_o, err_o     locked indication, sticky protocol error
//   pkt_cnt_o         completed-packet counter (wraps)
module wormhole_arbiter #(
  parameter int N_REQ     = 5,
  parameter int MAX_FLITS = 256,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [N_REQ-1:0] req_i,
  input  logic [N_REQ-1:0] head_i,
  input  logic [N_REQ-1:0] tail_i,
  input  logic             ready_i,
  output logic [N_REQ-1:0] grant_o,
  output logic             valid_o,
  output logic [N_REQ-1:0] ready_o,
  output logic             busy_o,
  output logic             err_o,
  output logic [CNT_W-1:0] pkt_cnt_o
);

  localparam int OW = $clog2(N_REQ);
  localparam int FW = $clog2(MAX_FLITS + 1);
  localparam logic [N_REQ-1:0] REQ_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [FW-1:0]    flit_cnt_q, flit_cnt_d;
  logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
  logic             err_q, err_d;

  logic [N_REQ-1:0] eligible;
  logic             pick_vld;
  logic [OW-1:0]    pick_idx;
  logic [OW-1:0]    nxt_ptr;
  logic             xfer;
  logic             own_head;
  logic             own_tail;
  logic [FW-1:0]    flit_inc;

  assign eligible = req_i & head_i;

  // Circular search starting at rr_ptr. Iterating from the far end down
  // lets the closest eligible requester overwrite any farther one.
  always_comb begin
    int idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (eligible[idx]) begin
        pick_vld = 1'b1;
        pick_idx = OW'(idx);
      end
    end
  end

  assign nxt_ptr  = (owner_q == OW'(N_REQ - 1)) ? '0 : owner_q + OW'(1);
  assign valid_o  = |(grant_q & req_i);
  assign ready_o  = grant_q & {N_REQ{ready_i}};
  assign xfer     = valid_o & ready_i;
  // grant_q is one-hot, so masking selects the owner's flit type.
  assign own_head = |(grant_q & head_i);
  assign own_tail = |(grant_q & tail_i);
  assign flit_inc = flit_cnt_q + FW'(1);

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    flit_cnt_d = flit_cnt_q;
    pkt_cnt_d  = pkt_cnt_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = LOCKED;
          owner_d = pick_idx;
          grant_d = REQ_ONE << pick_idx;
        end
      end
      LOCKED: begin
        if (xfer) begin
          // A head inside a packet is flagged but still forwarded.
          if (own_head && (flit_cnt_q != '0)) err_d = 1'b1;
          if (own_tail) begin
            state_d    = IDLE;
            grant_d    = '0;
            rr_ptr_d   = nxt_ptr;
            flit_cnt_d = '0;
            pkt_cnt_d  = pkt_cnt_q + CNT_W'(1);
          end else if (flit_inc == FW'(MAX_FLITS)) begin
            // Runaway packet: drop the lock without counting it as complete.
            err_d      = 1'b1;
            state_d    = IDLE;
            grant_d    = '0;
            rr_ptr_d   = nxt_ptr;
            flit_cnt_d = '0;
          end else begin
            flit_cnt_d = flit_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      flit_cnt_q <= '0;
      pkt_cnt_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      flit_cnt_q <= flit_cnt_d;
      pkt_cnt_q  <= pkt_cnt_d;
      err_q      <= err_d;
    end
  end

  assign grant_o   = grant_q;
  assign busy_o    = (state_q == LOCKED);
  assign err_o     = err_q;
  assign pkt_cnt_o = pkt_cnt_q;

endmodule

// File: tb/tb_wormhole_arbiter.sv
module tb_wormhole_arbiter;

  localparam int N    = 5;
  localparam int MAXF = 4;
  localparam int CW   = 4;

  logic          clk = 1'b0;
  logic          arst;
  logic [N-1:0]  req_i, head_i, tail_i;
  logic          ready_i;
  logic [N-1:0]  grant_o, ready_o;
  logic          valid_o, busy_o, err_o;
  logic [CW-1:0] pkt_cnt_o;

  wormhole_arbiter #(.N_REQ(N), .MAX_FLITS(MAXF), .CNT_W(CW)) dut (
    .clk(clk), .arst(arst),
    .req_i(req_i), .head_i(head_i), .tail_i(tail_i), .ready_i(ready_i),
    .grant_o(grant_o), .valid_o(valid_o), .ready_o(ready_o),
    .busy_o(busy_o), .err_o(err_o), .pkt_cnt_o(pkt_cnt_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: owner index (-1 = idle), next-priority index,
  // transfers in current packet, completed packets, sticky error.
  int m_own, m_rr, m_fc, m_pkt;
  bit m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own = -1; m_rr = 0; m_fc = 0; m_pkt = 0; m_err = 0;
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    for (int i = 0; i < N; i++) eg[i] = (m_own == i);
    chk("grant",   32'(grant_o),   32'(eg));
    chk("valid",   32'(valid_o),   32'(|(eg & req_i)));
    chk("ready",   32'(ready_o),   32'(ready_i ? eg : '0));
    chk("busy",    32'(busy_o),    32'(m_own >= 0));
    chk("err",     32'(err_o),     32'(m_err));
    chk("pkt_cnt", 32'(pkt_cnt_o), 32'(m_pkt));
  endtask

  task automatic model_step();
    if (m_own < 0) begin
      for (int k = 0; k < N; k++)
        if (m_own < 0 && req_i[(m_rr + k) % N] && head_i[(m_rr + k) % N])
          m_own = (m_rr + k) % N;
    end else if (req_i[m_own] && ready_i) begin
      if (head_i[m_own] && m_fc != 0) m_err = 1;
      if (tail_i[m_own]) begin
        m_pkt = (m_pkt + 1) % (1 << CW);
        m_rr  = (m_own + 1) % N;
        m_own = -1;
        m_fc  = 0;
      end else begin
        m_fc++;
        if (m_fc == MAXF) begin
          m_err = 1;
          m_rr  = (m_own + 1) % N;
          m_own = -1;
          m_fc  = 0;
        end
      end
    end
  endtask

  // One cycle: drive at negedge, check, let the edge happen, update model.
  task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] h,
                     input logic [N-1:0] t, input logic rd);
    req_i = r; head_i = h; tail_i = t; ready_i = rd;
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic async_reset_check(input string tag);
    #2;
    arst = 1'b0;
    #1;
    chk({tag, "_grant"}, 32'(grant_o),   32'h0);
    chk({tag, "_valid"}, 32'(valid_o),   32'h0);
    chk({tag, "_ready"}, 32'(ready_o),   32'h0);
    chk({tag, "_busy"},  32'(busy_o),    32'h0);
    chk({tag, "_err"},   32'(err_o),     32'h0);
    chk({tag, "_pkt"},   32'(pkt_cnt_o), 32'h0);
    model_reset();
    @(negedge clk);
    arst = 1'b1;
  endtask

  initial begin
    logic [N-1:0] seq[$];
    int exp_ord[6];
    exp_ord = '{0, 1, 2, 3, 4, 0};

    arst = 1'b0; req_i = '0; head_i = '0; tail_i = '0; ready_i = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("por_grant", 32'(grant_o),   32'h0);
    chk("por_busy",  32'(busy_o),    32'h0);
    chk("por_err",   32'(err_o),     32'h0);
    chk("por_pkt",   32'(pkt_cnt_o), 32'h0);
    arst = 1'b1;

    // Head on requester 2 only: granted one cycle later.
    cyc(5'b00000, 5'b00000, 5'b00000, 1'b0);
    cyc(5'b00100, 5'b00100, 5'b00100, 1'b0);
    chk("grant_lat", 32'(grant_o), 32'h04);
    cyc(5'b00100, 5'b00100, 5'b00100, 1'b0);
    async_reset_check("midrst");

    // Round-robin: all five send 1-flit packets back to back.
    for (int c = 0; c < 12; c++) begin
      cyc(5'b11111, 5'b11111, 5'b11111, 1'b1);
      if (grant_o != '0) seq.push_back(grant_o);
    end
    chk("rr_len", 32'(seq.size()), 32'd6);
    for (int i = 0; i < 6; i++)
      if (i < seq.size()) chk("rr_order", 32'(seq[i]), 32'(1) << exp_ord[i]);
    chk("rr_pkt", 32'(pkt_cnt_o), 32'd6);

    // Wormhole lock: req 1 sends 4 flits, req 3 waits with a head.
    cyc(5'b00010, 5'b00010, 5'b00000, 1'b1);
    cyc(5'b00010, 5'b00010, 5'b00000, 1'b1);
    cyc(5'b01010, 5'b01000, 5'b00000, 1'b1);
    cyc(5'b01010, 5'b01000, 5'b00000, 1'b0);
    cyc(5'b01010, 5'b01000, 5'b00000, 1'b1);
    cyc(5'b01010, 5'b01000, 5'b00010, 1'b1);
    chk("wh_bubble", 32'(grant_o), 32'h0);
    cyc(5'b01000, 5'b01000, 5'b00000, 1'b1);
    chk("wh_grant3", 32'(grant_o), 32'h08);
    cyc(5'b01000, 5'b01000, 5'b01000, 1'b1);

    // Backpressure on a tail flit.
    cyc(5'b10000, 5'b10000, 5'b00000, 1'b1);
    cyc(5'b10000, 5'b10000, 5'b00000, 1'b1);
    for (int c = 0; c < 3; c++) cyc(5'b10000, 5'b00000, 5'b10000, 1'b0);
    chk("bp_busy", 32'(busy_o),    32'd1);
    chk("bp_pkt",  32'(pkt_cnt_o), 32'd8);
    cyc(5'b10000, 5'b00000, 5'b10000, 1'b1);
    chk("bp_rel",     32'(busy_o),    32'd0);
    chk("bp_pkt_inc", 32'(pkt_cnt_o), 32'd9);

    // Length guard: four transfers with no tail.
    cyc(5'b00100, 5'b00100, 5'b00000, 1'b1);
    cyc(5'b00100, 5'b00100, 5'b00000, 1'b1);
    for (int c = 0; c < 3; c++) cyc(5'b00100, 5'b00000, 5'b00000, 1'b1);
    chk("lg_err",  32'(err_o),     32'd1);
    chk("lg_busy", 32'(busy_o),    32'd0);
    chk("lg_pkt",  32'(pkt_cnt_o), 32'd9);
    cyc(5'b00000, 5'b00000, 5'b00000, 1'b1);
    async_reset_check("errclr");

    // Second head inside a packet.
    cyc(5'b00010, 5'b00010, 5'b00000, 1'b1);
    cyc(5'b00010, 5'b00010, 5'b00000, 1'b1);
    cyc(5'b00010, 5'b00010, 5'b00000, 1'b1);
    chk("pe_err",  32'(err_o),  32'd1);
    chk("pe_lock", 32'(busy_o), 32'd1);
    cyc(5'b00010, 5'b00000, 5'b00010, 1'b1);
    chk("pe_sticky", 32'(err_o),     32'd1);
    chk("pe_pkt",    32'(pkt_cnt_o), 32'd1);

    async_reset_check("prerand");
    for (int c = 0; c < 1500; c++) begin
      cyc(5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31) & $urandom_range(0, 31)),
          5'($urandom_range(0, 31) & $urandom_range(0, 31)),
          ($urandom_range(0, 3) != 0));
    end
    cyc(5'b00000, 5'b00000, 5'b00000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wormhole_arbiter.md
# wormhole_arbiter

Per-output-port arbiter for the mesh router. It shares one output module among N input modules with round-robin priority and wormhole locking: a grant is taken on a head flit and held until that packet's tail flit transfers. It sits between the input modules' route requests and the output module's datapath, and drives the per-requester ready back to the input datapath FIFOs.

## Interface
- N_REQ, 5, number of requesting input modules (≥2)
- MAX_FLITS, 256, packet-length guard; forced release after this many flits without a tail
- CNT_W, 16, width of completed-packet counter
- clk  in  1  router clock
- arst  in  1  asynchronous reset, active-low
- req_i  in  N_REQ  requester i presents a valid flit routed to this output
- head_i  in  N_REQ  requester i's presented flit is a head flit
- tail_i  in  N_REQ  requester i's presented flit is a tail flit (head+tail = single-flit packet)
- ready_i  in  1  output module accepts a flit this cycle
- grant_o  out  N_REQ  one-hot current owner; zero when idle
- valid_o  out  1  owner is presenting a flit: |(grant_o & req_i)
- ready_o  out  N_REQ  grant_o & {N_REQ{ready_i}}; per-requester pop
- busy_o  out  1  arbiter locked to an owner
- err_o  out  1  sticky protocol error; cleared only by reset
- pkt_cnt_o  out  CNT_W  completed packets, wraps modulo 2^CNT_W

## Operation
- Transfer = valid_o & ready_i.
- FSM IDLE: eligible = req_i & head_i. If nonzero, pick first eligible at or after rr_ptr (circular search, wrap N_REQ-1→0); register owner, go LOCKED. Requests without head_i are ignored in IDLE (not granted, no error).
- FSM LOCKED: grant_o = onehot(owner). On transfer with tail_i[owner]: go IDLE, rr_ptr ← owner+1 (wrap to 0 at N_REQ), pkt_cnt += 1, flit_cnt ← 0.
- Transfer without tail: flit_cnt += 1.
- Transfer of a head flit (head_i[owner], flit_cnt ≠ 0) while LOCKED: err_o ← 1; flit still passes, lock kept.
- flit_cnt reaches MAX_FLITS with no tail: err_o ← 1, forced release to IDLE, rr_ptr ← owner+1, pkt_cnt not incremented.
- Owner dropping req_i mid-packet: valid_o = 0, lock held (no timeout other than the length guard, which counts only transfers).
- Non-owner requests in LOCKED are stalled (ready_o bit 0).
- flit_cnt width = clog2(MAX_FLITS+1).

## Timing
- Reset (arst low, async): state IDLE, owner 0, rr_ptr 0, flit_cnt 0, pkt_cnt_o 0, err_o 0; so grant_o 0, valid_o 0, ready_o 0, busy_o 0.
- Grant latency: eligible head seen in IDLE at cycle t → grant_o/busy_o asserted from t+1. grant_o is a register output; valid_o/ready_o are combinational from it.
- Tail transfer at cycle t → grant_o 0 at t+1 (one-cycle arbitration bubble between packets), new grant at t+2 at earliest.
- Single-flit packet (head_i&tail_i) transfers in the first LOCKED cycle it is accepted; release as tail.
- Simultaneous eligible heads: only rr_ptr order matters; ties impossible.
- Reset asserted mid-packet: lock dropped immediately; the input side must discard/flush its partial packet.
- pkt_cnt_o updates the cycle after the tail transfer.

## Test plan
- Reset: drive arst low mid-traffic → all outputs 0 asynchronously; after release, head on req 2 only → grant_o=00100 one cycle later.
- Round-robin: N_REQ=5, all five present 1-flit packets continuously, ready_i=1 → grant order 0,1,2,3,4,0 with one idle cycle between grants; pkt_cnt_o=6.
- Wormhole lock: req 1 sends 4-flit packet, req 3 raises head at flit 2 with ready_i toggling 1,0,1 → req 3 ready_o stays 0 until req 1 tail transfers; req 3 granted 2 cycles after tail.
- Backpressure: owner presents tail, ready_i=0 for 3 cycles → grant held, no release, pkt_cnt unchanged; release the cycle after ready_i=1.
- Length guard: MAX_FLITS=4, owner sends 4 body flits, no tail → err_o=1 after 4th transfer, busy_o=0 next cycle, pkt_cnt_o unchanged.
- Protocol error: owner presents second head mid-packet → err_o=1 sticky, lock kept, packet completes on later tail.
